pipeline_debug_ctrl: RTL and testbench

PIPELINE_DEBUG_CTRL -- requirements
Module: pipeline_debug_ctrl

---
 rtl/pipeline_dbg_pkg.sv | 22 ++
 rtl/dbg_word_tx.sv | 65 ++++++
 rtl/pipeline_debug_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipeline_debug_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_dbg_pkg.sv
// Shared command codes, FSM state encoding and dump framing constants for the
// pipeline debug controller.
package pipeline_dbg_pkg;

  localparam int unsigned NB_BYTE        = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  localparam logic [NB_BYTE-1:0] CMD_RUN   = 8'h52;
  localparam logic [NB_BYTE-1:0] CMD_STEP  = 8'h53;
  localparam logic [NB_BYTE-1:0] CMD_DUMP  = 8'h44;
  localparam logic [NB_BYTE-1:0] CMD_BREAK = 8'h42;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_FETCH = 3'd3,
    ST_WAIT  = 3'd4,
    ST_SEND  = 3'd5
  } dbg_state_e;

endpackage

// File: rtl/dbg_word_tx.sv
// Serializes one data word into BYTES_PER_WORD valid/ready byte transfers,
// most significant byte first.
module dbg_word_tx
  import pipeline_dbg_pkg::*;
#(
  parameter int unsigned NB_DATA = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_done_c
);

  localparam int unsigned NB_CNT = $clog2(BYTES_PER_WORD);
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(BYTES_PER_WORD - 1);

  logic [NB_DATA-1:0] word_q, word_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               xfer;
  logic               last;

  assign xfer = valid_q & i_tx_ready;
  assign last = (cnt_q == LAST_BYTE);

  // Shift register holds the current byte in its top bits until accepted
  always_comb begin
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (i_load) begin
      word_d  = i_word;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      if (last) begin
        valid_d = 1'b0;
      end else begin
        word_d = word_q << NB_BYTE;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign o_tx_data  = word_q[NB_DATA-1 -: NB_BYTE];
  assign o_tx_valid = valid_q;
  assign o_done_c   = xfer & last;

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Debug controller: run/step/break the pipeline from a command byte stream and
// dump PC, register file and (with DEBUG_MEM_DUMP_EN) data memory as bytes.
module pipeline_debug_ctrl
  import pipeline_dbg_pkg::*;
#(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_REG_ADDR = 5,
  parameter int unsigned NB_MEM_ADDR = 5
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NB_BYTE-1:0]     i_cmd_data,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_pipe_en,
  input  logic                   i_halt,
  input  logic [NB_DATA-1:0]     i_pc,
  output logic [NB_REG_ADDR-1:0] o_reg_rd_addr,
  input  logic [NB_DATA-1:0]     i_reg_rd_data,
  output logic [NB_MEM_ADDR-1:0] o_mem_rd_addr,
  input  logic [NB_DATA-1:0]     i_mem_rd_data,
  output logic                   o_busy
);

  localparam int unsigned NUM_REGS = 1 << NB_REG_ADDR;
`ifdef DEBUG_MEM_DUMP_EN
  localparam int unsigned NUM_MEMS  = 1 << NB_MEM_ADDR;
  localparam int unsigned NUM_WORDS = 1 + NUM_REGS + NUM_MEMS;
`else
  localparam int unsigned NUM_WORDS = 1 + NUM_REGS;
`endif
  localparam int unsigned NB_IDX =
    ((NB_REG_ADDR > NB_MEM_ADDR) ? NB_REG_ADDR : NB_MEM_ADDR) + 2;
  localparam logic [NB_IDX-1:0] LAST_IDX     = NB_IDX'(NUM_WORDS - 1);
  localparam logic [NB_IDX-1:0] REG_LAST_IDX = NB_IDX'(NUM_REGS);

  dbg_state_e               state_q, state_d;
  logic                     halted_q, halted_d;
  logic [NB_IDX-1:0]        idx_q, idx_d;
  logic                     pipe_en_q, pipe_en_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     busy_q, busy_d;
  logic [NB_REG_ADDR-1:0]   reg_addr_q, reg_addr_d;
  logic                     cmd_fire;
  logic                     tx_load_c;
  logic [NB_DATA-1:0]       tx_word_c;
  logic                     tx_done_c;

  assign cmd_fire = i_cmd_valid & cmd_ready_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, halted flag and dump word index
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    idx_d    = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (i_cmd_data)
            CMD_RUN:  if (!halted_q) state_d = ST_RUN;
            CMD_STEP: if (!halted_q) state_d = ST_STEP;
            CMD_DUMP: state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          halted_d = 1'b1;
          state_d  = ST_FETCH;
        end else if (cmd_fire && (i_cmd_data == CMD_BREAK)) begin
          state_d = ST_FETCH;
        end
      end
      ST_STEP: begin
        if (i_halt) halted_d = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: state_d = (idx_q == '0) ? ST_SEND : ST_WAIT;
      ST_WAIT:  state_d = ST_SEND;
      ST_SEND: begin
        if (tx_done_c) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered-output next values and serializer load
  always_comb begin
    pipe_en_d   = (state_d == ST_RUN) || (state_d == ST_STEP);
    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN);
    busy_d      = (state_d != ST_IDLE);
    reg_addr_d  = reg_addr_q;
    if ((state_d == ST_FETCH) && (idx_d != '0) && (idx_d <= REG_LAST_IDX)) begin
      reg_addr_d = NB_REG_ADDR'(idx_d - 1'b1);
    end
    tx_load_c = ((state_q == ST_FETCH) && (idx_q == '0)) || (state_q == ST_WAIT);
    tx_word_c = i_pc;
    if (state_q == ST_WAIT) begin
`ifdef DEBUG_MEM_DUMP_EN
      tx_word_c = (idx_q <= REG_LAST_IDX) ? i_reg_rd_data : i_mem_rd_data;
`else
      tx_word_c = i_reg_rd_data;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      halted_q    <= 1'b0;
      idx_q       <= '0;
      pipe_en_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      reg_addr_q  <= '0;
    end else begin
      halted_q    <= halted_d;
      idx_q       <= idx_d;
      pipe_en_q   <= pipe_en_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      reg_addr_q  <= reg_addr_d;
    end
  end

`ifdef DEBUG_MEM_DUMP_EN
  logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;

  always_comb begin
    mem_addr_d = mem_addr_q;
    if ((state_d == ST_FETCH) && (idx_d > REG_LAST_IDX)) begin
      mem_addr_d = NB_MEM_ADDR'(idx_d - REG_LAST_IDX - 1'b1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mem_addr_q <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
    end
  end

  assign o_mem_rd_addr = mem_addr_q;
`else
  logic unused_mem_rd_data;
  assign unused_mem_rd_data = ^i_mem_rd_data;
  assign o_mem_rd_addr      = '0;
`endif

  dbg_word_tx #(
    .NB_DATA (NB_DATA)
  ) u_word_tx (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (tx_load_c),
    .i_word     (tx_word_c),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_done_c   (tx_done_c)
  );

  assign o_pipe_en     = pipe_en_q;
  assign o_cmd_ready   = cmd_ready_q;
  assign o_busy        = busy_q;
  assign o_reg_rd_addr = reg_addr_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed bench for pipeline_debug_ctrl: step, run/break, halt, stalled dump,
// reset mid-dump and ignored commands, with hand-computed dump contents.
module tb_pipeline_debug_ctrl;

  localparam int unsigned NB_DATA     = 32;
  localparam int unsigned NB_REG_ADDR = 5;
  localparam int unsigned NB_MEM_ADDR = 5;
`ifdef DEBUG_MEM_DUMP_EN
  localparam int EXP_BYTES = 260;
`else
  localparam int EXP_BYTES = 132;
`endif

  logic                   i_clk = 1'b0;
  logic                   i_reset = 1'b1;
  logic [7:0]             i_cmd_data = 8'h00;
  logic                   i_cmd_valid = 1'b0;
  logic                   o_cmd_ready;
  logic [7:0]             o_tx_data;
  logic                   o_tx_valid;
  logic                   i_tx_ready = 1'b1;
  logic                   o_pipe_en;
  logic                   i_halt = 1'b0;
  logic [NB_DATA-1:0]     i_pc = 32'h0000_0004;
  logic [NB_REG_ADDR-1:0] o_reg_rd_addr;
  logic [NB_DATA-1:0]     i_reg_rd_data;
  logic [NB_MEM_ADDR-1:0] o_mem_rd_addr;
  logic [NB_DATA-1:0]     i_mem_rd_data;
  logic                   o_busy;

  pipeline_debug_ctrl #(
    .NB_DATA     (NB_DATA),
    .NB_REG_ADDR (NB_REG_ADDR),
    .NB_MEM_ADDR (NB_MEM_ADDR)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_cmd_data    (i_cmd_data),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_pipe_en     (o_pipe_en),
    .i_halt        (i_halt),
    .i_pc          (i_pc),
    .o_reg_rd_addr (o_reg_rd_addr),
    .i_reg_rd_data (i_reg_rd_data),
    .o_mem_rd_addr (o_mem_rd_addr),
    .i_mem_rd_data (i_mem_rd_data),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous-read register file and data memory models
  logic [31:0] regs [0:31];
  logic [31:0] mems [0:31];
  always @(posedge i_clk) begin
    i_reg_rd_data <= regs[o_reg_rd_addr];
    i_mem_rd_data <= mems[o_mem_rd_addr];
  end

  bit toggle_en = 1'b0;
  always @(posedge i_clk) begin
    #1;
    i_tx_ready = toggle_en ? ~i_tx_ready : 1'b1;
  end

  // Byte/pipe-enable monitor sampled mid-cycle
  logic [7:0] rx [0:4095];
  int   tx_count    = 0;
  int   pipe_cycles = 0;
  int   stall_viol  = 0;
  bit   stalled_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  always @(negedge i_clk) begin
    if (o_tx_valid && i_tx_ready) begin
      rx[tx_count & 4095] = o_tx_data;
      tx_count++;
    end
    if (o_pipe_en) pipe_cycles++;
    if (stalled_prev && !(o_tx_valid && (o_tx_data == stall_data))) stall_viol++;
    stalled_prev = o_tx_valid && !i_tx_ready && !i_reset;
    stall_data   = o_tx_data;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rx_word(input int off);
    return {rx[off & 4095], rx[(off + 1) & 4095], rx[(off + 2) & 4095], rx[(off + 3) & 4095]};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge i_clk);
  endtask

  // Present a command byte and return #1 after the accepting edge
  task automatic send_cmd(input logic [7:0] b);
    bit got;
    got = 1'b0;
    i_cmd_data  = b;
    i_cmd_valid = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge i_clk);
      got = o_cmd_ready;
    end
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    if (!got) check_eq("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    to_neg();
    while (o_busy && (n < budget)) begin
      to_neg();
      n++;
    end
    check_eq(tag, 32'(o_busy), 32'd0);
    tick();
  endtask

  int base;
  int pbase;
  int snap;

  initial begin
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'h1000_0000 | 32'(i);
      mems[i] = 32'h2000_0000 | 32'(i);
    end
    regs[3] = 32'hDEAD_BEEF;

    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    to_neg();
    check_eq("rst_pipe_en",   32'(o_pipe_en),     32'd0);
    check_eq("rst_tx_valid",  32'(o_tx_valid),    32'd0);
    check_eq("rst_tx_data",   32'(o_tx_data),     32'd0);
    check_eq("rst_cmd_ready", 32'(o_cmd_ready),   32'd1);
    check_eq("rst_busy",      32'(o_busy),        32'd0);
    check_eq("rst_reg_addr",  32'(o_reg_rd_addr), 32'd0);
    check_eq("rst_mem_addr",  32'(o_mem_rd_addr), 32'd0);
    tick();

    // Single step then automatic dump
    base = tx_count; pbase = pipe_cycles;
    send_cmd(8'h53);
    wait_idle(3000, "step_dump_done");
    check_eq("step_pipe_cycles", 32'(pipe_cycles - pbase), 32'd1);
    check_eq("step_byte_count",  32'(tx_count - base), 32'(EXP_BYTES));
    check_eq("step_pc_word",     rx_word(base), 32'h0000_0004);
    check_eq("step_reg0_word",   rx_word(base + 4), 32'h1000_0000);
    check_eq("step_reg3_word",   rx_word(base + 16), 32'hDEAD_BEEF);
    check_eq("step_reg31_lsb",   32'(rx[(base + 131) & 4095]), 32'h1F);
`ifdef DEBUG_MEM_DUMP_EN
    check_eq("step_mem0_word",   rx_word(base + 132), 32'h2000_0000);
    check_eq("step_mem31_word",  rx_word(base + 256), 32'h2000_001F);
`endif

    // Unknown byte in IDLE is swallowed
    base = tx_count; pbase = pipe_cycles;
    send_cmd(8'h41);
    to_neg();
    check_eq("junk_busy",      32'(o_busy), 32'd0);
    check_eq("junk_cmd_ready", 32'(o_cmd_ready), 32'd1);
    tick();
    repeat (5) tick();
    check_eq("junk_no_pipe", 32'(pipe_cycles - pbase), 32'd0);
    check_eq("junk_no_tx",   32'(tx_count - base), 32'd0);

    // Run, ignore 'S', then break
    i_pc = 32'h0000_0100;
    send_cmd(8'h52);
    to_neg();
    check_eq("run_pipe_en", 32'(o_pipe_en), 32'd1);
    check_eq("run_busy",    32'(o_busy), 32'd1);
    tick();
    send_cmd(8'h53);
    to_neg();
    check_eq("run_ignore_s_pipe", 32'(o_pipe_en), 32'd1);
    check_eq("run_ignore_s_rdy",  32'(o_cmd_ready), 32'd1);
    tick();
    repeat (10) tick();
    base = tx_count;
    send_cmd(8'h42);
    to_neg();
    check_eq("brk_pipe_off",  32'(o_pipe_en), 32'd0);
    check_eq("brk_cmd_ready", 32'(o_cmd_ready), 32'd0);
    tick();
    wait_idle(3000, "brk_dump_done");
    check_eq("brk_byte_count", 32'(tx_count - base), 32'(EXP_BYTES));
    check_eq("brk_pc_word",    rx_word(base), 32'h0000_0100);

    // Break left halted flag clear: run again, then halt from WB
    send_cmd(8'h52);
    to_neg();
    check_eq("rerun_pipe_en", 32'(o_pipe_en), 32'd1);
    tick();
    repeat (18) tick();
    i_pc = 32'h0000_0200;
    base = tx_count;
    i_halt = 1'b1;
    tick();
    i_halt = 1'b0;
    to_neg();
    check_eq("halt_pipe_off", 32'(o_pipe_en), 32'd0);
    check_eq("halt_busy",     32'(o_busy), 32'd1);
    tick();
    wait_idle(3000, "halt_dump_done");
    check_eq("halt_byte_count", 32'(tx_count - base), 32'(EXP_BYTES));
    check_eq("halt_pc_word",    rx_word(base), 32'h0000_0200);

    // Halted: 'R' and 'S' consumed with no activity
    pbase = pipe_cycles;
    send_cmd(8'h52);
    to_neg();
    check_eq("halted_r_pipe", 32'(o_pipe_en), 32'd0);
    check_eq("halted_r_busy", 32'(o_busy), 32'd0);
    tick();
    send_cmd(8'h53);
    to_neg();
    check_eq("halted_s_busy", 32'(o_busy), 32'd0);
    tick();
    check_eq("halted_no_pipe", 32'(pipe_cycles - pbase), 32'd0);

    // Dump while halted with a stalling sink
    toggle_en = 1'b1;
    base = tx_count;
    stall_viol = 0;
    send_cmd(8'h44);
    wait_idle(6000, "stall_dump_done");
    toggle_en = 1'b0;
    check_eq("stall_byte_count", 32'(tx_count - base), 32'(EXP_BYTES));
    check_eq("stall_reg3_word",  rx_word(base + 16), 32'hDEAD_BEEF);
    check_eq("stall_reg1_word",  rx_word(base + 8), 32'h1000_0001);
    check_eq("stall_stable",     32'(stall_viol), 32'd0);
    repeat (2) tick();

    // Reset in the middle of a dump
    base = tx_count;
    send_cmd(8'h44);
    for (int n = 0; n < 2000 && (tx_count - base) < 50; n++) to_neg();
    check_eq("mid_dump_reached", 32'((tx_count - base) >= 50), 32'd1);
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    to_neg();
    check_eq("abort_tx_valid",  32'(o_tx_valid), 32'd0);
    check_eq("abort_busy",      32'(o_busy), 32'd0);
    check_eq("abort_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check_eq("abort_tx_data",   32'(o_tx_data), 32'd0);
    snap = tx_count;
    tick();
    repeat (300) tick();
    check_eq("abort_no_more_tx", 32'(tx_count - snap), 32'd0);

    // Reset cleared the halted flag
    send_cmd(8'h52);
    to_neg();
    check_eq("reset_clears_halt", 32'(o_pipe_en), 32'd1);
    tick();
    send_cmd(8'h42);
    wait_idle(3000, "final_dump_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
